move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 The block SHALL use these parameters:
- DEPTH, 4, move queue depth (power of two, 2..16)
- STEP_W, 6, step counter width
REQ-002 The block SHALL have these ports:
- sys_clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- game_status  in  2  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
- act_flag  in  4  one-cycle debounced direction pulses; index = direction code 0..3
- reset_flag  in  1  one-cycle board-restart pulse
- win_flag  in  1  level; board solved
- mv_valid  out  1  move offered to board datapath
- mv_dir  out  2  direction of offered move
- mv_ready  in  1  datapath accepts move this cycle
- clr_req  out  1  one-cycle pulse; datapath reloads initial board
- step_number  out  STEP_W  accepted-move count
- queue_full  out  1  queue holds DEPTH entries
- overflow  out  1  sticky; a move was dropped

Function
REQ-003 The block SHALL implement states IDLE, RUN, CLEAR, WON.
REQ-004 IDLE -> RUN when game_status==GAMING; otherwise stay in IDLE.
REQ-005 RUN -> CLEAR on reset_flag; RUN -> WON on win_flag (reset_flag has priority); RUN -> IDLE when game_status is CHOSE_BOARD or GAME_INITIAL.
REQ-006 CLEAR SHALL last exactly one cycle, assert clr_req, flush the queue, zero step_number, clear overflow, then go to RUN if game_status==GAMING, else IDLE.
REQ-007 WON SHALL flush the queue, hold step_number, and go to CLEAR on reset_flag or to IDLE when game_status==CHOSE_BOARD.
REQ-008 Entering RUN from IDLE SHALL zero step_number and clear overflow.
REQ-009 Enqueue SHALL occur only in RUN, when act_flag!=0 and reset_flag==0 and win_flag==0.
REQ-010 When multiple act_flag bits are set, the block SHALL enqueue only the lowest set index (fixed priority); other bits are discarded.
REQ-011 The queue SHALL be FIFO; mv_dir SHALL be the head entry; mv_valid = (state==RUN) and queue non-empty.
REQ-012 A move SHALL be accepted on mv_valid and mv_ready in the same cycle; the head is popped on that edge.
REQ-013 mv_dir SHALL be stable while mv_valid is high and mv_ready is low.
REQ-014 Latency: an act_flag pulse in cycle N into an empty queue SHALL give mv_valid=1 in cycle N+1; no combinational path from act_flag to mv_valid.
REQ-015 Simultaneous push and pop while full SHALL succeed with occupancy unchanged.
REQ-016 A push while full without a pop SHALL be dropped and set overflow.
REQ-017 A push while empty SHALL NOT be visible as mv_valid in the same cycle.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be a separate counter of width log2(DEPTH)+1.
REQ-019 queue_full SHALL be registered from occupancy==DEPTH.
REQ-020 step_number SHALL increment by 1 per accepted move and saturate at 2^STEP_W-1 (63).
REQ-021 Entering WON or IDLE SHALL drop mv_valid in the next cycle, even if the datapath has not accepted the move; the move is discarded, not replayed.

Reset
REQ-022 On rst the block SHALL set state IDLE, empty the queue, and drive mv_valid=0, mv_dir=0, clr_req=0, step_number=0, queue_full=0, overflow=0.
REQ-023 rst SHALL override all other inputs in the same cycle, including mid-handshake and during CLEAR.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- GAMING, act_flag=0100 at cycle N, mv_ready=1 -> mv_valid=1, mv_dir=2 at N+1; step_number=1 at N+2.
- act_flag=1010 in one cycle -> single entry, mv_dir=1.
- mv_ready=0, five pulses of directions 0,1,2,3,0 -> queue_full=1, overflow=1, fifth dropped; with mv_ready=1, outputs are 0,1,2,3 in order.
- 70 accepted moves -> step_number stops at 63.
- reset_flag and act_flag together in RUN -> clr_req one cycle, nothing queued, step_number=0, overflow=0, back to RUN.
- win_flag with 2 queued moves -> mv_valid=0 next cycle, step_number held; game_status=00 -> IDLE.
- rst asserted while mv_valid=1 and mv_ready=0 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/move_scheduler_if.sv
// move_scheduler_if: move handshake between the scheduler and the board datapath.
interface move_scheduler_if;
  logic       mv_valid;
  logic [1:0] mv_dir;
  logic       mv_ready;
  modport master (output mv_valid, mv_dir, input mv_ready);
  modport slave (input mv_valid, mv_dir, output mv_ready);
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: queues debounced direction pulses and offers them one at a time to the board datapath.
module move_scheduler #(
  parameter int DEPTH  = 4,
  parameter int STEP_W = 6
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [1:0]        game_status,
  input  logic [3:0]        act_flag,
  input  logic              reset_flag,
  input  logic              win_flag,
  move_scheduler_if.master  mv,
  output logic              clr_req,
  output logic [STEP_W-1:0] step_number,
  output logic              queue_full,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, CLEAR, WON} state_t;
  state_t state, nxt;
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count, count_nxt;
  logic [1:0] dir;
  logic push, pop, do_push, zero;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = game_status == 2'b01 ? RUN : IDLE;
      RUN:   nxt = reset_flag ? CLEAR : win_flag ? WON : game_status[0] ? RUN : IDLE;
      CLEAR: nxt = game_status == 2'b01 ? RUN : IDLE;
      WON:   nxt = reset_flag ? CLEAR : game_status == 2'b00 ? IDLE : WON;
      default: nxt = IDLE;
    endcase
  end
  assign dir = act_flag[0] ? 2'd0 : act_flag[1] ? 2'd1 : act_flag[2] ? 2'd2 : 2'd3;
  assign mv.mv_valid = state == RUN && count != '0;
  assign mv.mv_dir = mv.mv_valid ? mem[rd] : 2'd0;
  assign clr_req = state == CLEAR;
  assign pop = mv.mv_valid && mv.mv_ready;
  assign push = state == RUN && |act_flag && !reset_flag && !win_flag;
  // A full queue still takes a push when the head leaves on the same edge.
  assign do_push = push && (count != CW'(DEPTH) || pop);
  assign count_nxt = count + CW'(do_push) - CW'(pop);
  assign zero = nxt == CLEAR || (state == IDLE && nxt == RUN);
  always_ff @(posedge sys_clk)
    if (do_push) mem[wr] <= dir;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      rd          <= '0;
      wr          <= '0;
      count       <= '0;
      queue_full  <= 1'b0;
      step_number <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= nxt;
      if (state != RUN) begin
        rd         <= '0;
        wr         <= '0;
        count      <= '0;
        queue_full <= 1'b0;
      end else begin
        if (do_push) wr <= wr + 1'b1;
        if (pop) rd <= rd + 1'b1;
        count      <= count_nxt;
        queue_full <= count_nxt == CW'(DEPTH);
      end
      if (zero) step_number <= '0;
      else if (pop && step_number != {STEP_W{1'b1}}) step_number <= step_number + 1'b1;
      if (zero) overflow <= 1'b0;
      else if (push && !do_push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed checks of queueing, handshake, saturation, clear, win and reset behaviour.
module tb_move_scheduler;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] game_status = 2'b00;
  logic [3:0] act_flag = 4'b0;
  logic       reset_flag = 1'b0;
  logic       win_flag = 1'b0;
  logic       clr_req, queue_full, overflow;
  logic [5:0] step_number;
  int checks = 0;
  int passed = 0;
  move_scheduler_if mv ();
  move_scheduler #(.DEPTH(4), .STEP_W(6)) dut (
    .sys_clk(sys_clk), .rst(rst), .game_status(game_status), .act_flag(act_flag),
    .reset_flag(reset_flag), .win_flag(win_flag), .mv(mv), .clr_req(clr_req),
    .step_number(step_number), .queue_full(queue_full), .overflow(overflow)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  initial begin
    mv.mv_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 8'(mv.mv_valid), 8'd0);
    chk("rst_dir", 8'(mv.mv_dir), 8'd0);
    chk("rst_clr", 8'(clr_req), 8'd0);
    chk("rst_step", 8'(step_number), 8'd0);
    chk("rst_full", 8'(queue_full), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);
    rst = 1'b0;
    game_status = 2'b01;
    tick();
    // single move: latency and acceptance
    mv.mv_ready = 1'b1;
    act_flag = 4'b0100;
    chk("same_cycle_valid", 8'(mv.mv_valid), 8'd0);
    tick();
    act_flag = 4'b0;
    chk("lat_valid", 8'(mv.mv_valid), 8'd1);
    chk("lat_dir", 8'(mv.mv_dir), 8'd2);
    tick();
    chk("lat_step", 8'(step_number), 8'd1);
    chk("lat_empty", 8'(mv.mv_valid), 8'd0);
    // multi-bit pulse keeps lowest index only
    mv.mv_ready = 1'b0;
    act_flag = 4'b1010;
    tick();
    act_flag = 4'b0;
    chk("prio_dir", 8'(mv.mv_dir), 8'd1);
    tick();
    chk("stall_valid", 8'(mv.mv_valid), 8'd1);
    chk("stall_dir", 8'(mv.mv_dir), 8'd1);
    mv.mv_ready = 1'b1;
    tick();
    chk("prio_single", 8'(mv.mv_valid), 8'd0);
    chk("prio_step", 8'(step_number), 8'd2);
    // fill, overflow, push+pop while full, drain
    mv.mv_ready = 1'b0;
    for (int d = 0; d < 4; d++) begin
      act_flag = 4'(1 << d);
      tick();
    end
    chk("fill_full", 8'(queue_full), 8'd1);
    chk("fill_ovf", 8'(overflow), 8'd0);
    act_flag = 4'b0001;
    tick();
    chk("drop_ovf", 8'(overflow), 8'd1);
    chk("drop_full", 8'(queue_full), 8'd1);
    chk("drop_head", 8'(mv.mv_dir), 8'd0);
    mv.mv_ready = 1'b1;
    tick();
    act_flag = 4'b0;
    chk("pp_full", 8'(queue_full), 8'd1);
    chk("pp_dir1", 8'(mv.mv_dir), 8'd1);
    tick();
    chk("pp_dir2", 8'(mv.mv_dir), 8'd2);
    tick();
    chk("pp_dir3", 8'(mv.mv_dir), 8'd3);
    tick();
    chk("pp_dir0", 8'(mv.mv_dir), 8'd0);
    chk("pp_notfull", 8'(queue_full), 8'd0);
    tick();
    chk("drain_valid", 8'(mv.mv_valid), 8'd0);
    chk("drain_step", 8'(step_number), 8'd7);
    // restart together with a direction pulse
    reset_flag = 1'b1;
    act_flag = 4'b0001;
    tick();
    reset_flag = 1'b0;
    act_flag = 4'b0;
    chk("clr_pulse", 8'(clr_req), 8'd1);
    chk("clr_step", 8'(step_number), 8'd0);
    chk("clr_ovf", 8'(overflow), 8'd0);
    tick();
    chk("clr_done", 8'(clr_req), 8'd0);
    chk("clr_noqueue", 8'(mv.mv_valid), 8'd0);
    tick();
    chk("clr_still_empty", 8'(mv.mv_valid), 8'd0);
    // 70 accepted moves saturate the counter
    for (int i = 0; i < 70; i++) begin
      act_flag = 4'b0001;
      tick();
    end
    act_flag = 4'b0;
    tick();
    chk("sat_step", 8'(step_number), 8'd63);
    chk("sat_empty", 8'(mv.mv_valid), 8'd0);
    // win with two queued moves
    mv.mv_ready = 1'b0;
    act_flag = 4'b0100;
    tick();
    act_flag = 4'b1000;
    tick();
    act_flag = 4'b0;
    chk("win_pre_valid", 8'(mv.mv_valid), 8'd1);
    chk("win_pre_dir", 8'(mv.mv_dir), 8'd2);
    win_flag = 1'b1;
    tick();
    chk("win_valid", 8'(mv.mv_valid), 8'd0);
    chk("win_step", 8'(step_number), 8'd63);
    game_status = 2'b00;
    tick();
    chk("idle_valid", 8'(mv.mv_valid), 8'd0);
    chk("idle_step", 8'(step_number), 8'd63);
    win_flag = 1'b0;
    game_status = 2'b01;
    tick();
    chk("rerun_step", 8'(step_number), 8'd0);
    chk("rerun_noreplay", 8'(mv.mv_valid), 8'd0);
    // reset mid-handshake
    mv.mv_ready = 1'b1;
    act_flag = 4'b0001;
    tick();
    act_flag = 4'b0;
    tick();
    chk("pre_rst_step", 8'(step_number), 8'd1);
    mv.mv_ready = 1'b0;
    act_flag = 4'b0010;
    tick();
    act_flag = 4'b0;
    chk("pre_rst_valid", 8'(mv.mv_valid), 8'd1);
    chk("pre_rst_dir", 8'(mv.mv_dir), 8'd1);
    rst = 1'b1;
    tick();
    chk("hs_rst_valid", 8'(mv.mv_valid), 8'd0);
    chk("hs_rst_dir", 8'(mv.mv_dir), 8'd0);
    chk("hs_rst_clr", 8'(clr_req), 8'd0);
    chk("hs_rst_step", 8'(step_number), 8'd0);
    chk("hs_rst_full", 8'(queue_full), 8'd0);
    chk("hs_rst_ovf", 8'(overflow), 8'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_empty", 8'(mv.mv_valid), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
